// File: rtl/ex_muldiv_issue.sv
// ex_muldiv_issue: EX-stage issue sequencer that holds ALU operands across multi-cycle mul/div and hands results to MEM
module ex_muldiv_issue #(
    parameter int DW      = 32,
    parameter int OPW     = 19,
    parameter int DIV_MAX = 40
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ds_to_es_valid,
    output logic           es_allowin,
    input  logic [OPW-1:0] ds_alu_op,
    input  logic [DW-1:0]  ds_src1,
    input  logic [DW-1:0]  ds_src2,
    input  logic [4:0]     ds_dest,
    input  logic           flush,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_src1,
    output logic [DW-1:0]  alu_src2,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_complete,
    input  logic           mul_valid,
    input  logic [DW-1:0]  mul_result,
    output logic           es_to_ms_valid,
    input  logic           ms_allowin,
    output logic [DW-1:0]  es_result,
    output logic [4:0]     es_dest,
    output logic           es_busy,
    output logic           err_timeout
);
    localparam logic [2:0] EMPTY = 3'd0, EXEC = 3'd1, MULW = 3'd2, DIVW = 3'd3, HOLD = 3'd4, DRAIN = 3'd5;
    localparam int CW = $clog2(DIV_MAX + 1);
    localparam logic [CW-1:0] CMAX = CW'(DIV_MAX);
    logic [2:0]     state, state_n;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  src1_q, src2_q, res_q, res_n;
    logic [4:0]     dest_q;
    logic [CW-1:0]  cnt;
    logic           is_mul, is_div, accept, cap, div_wait, mul_issued, mul_err;

    assign is_mul         = |op_q[14:12];
    assign is_div         = |op_q[18:15];
    assign div_wait       = state == DIVW || state == DRAIN;
    assign es_allowin     = !reset && (state == EMPTY || (state == HOLD && ms_allowin)) && !flush;
    assign accept         = es_allowin && ds_to_es_valid;
    assign alu_op         = (state == EXEC || div_wait) ? op_q : '0;
    assign alu_src1       = src1_q;
    assign alu_src2       = src2_q;
    assign es_to_ms_valid = state == HOLD;
    assign es_result      = res_q;
    assign es_dest        = dest_q;
    assign es_busy        = state != EMPTY;
    // a missing mul_valid in MULW, or one that no mul issue explains, is a protocol error
    assign mul_err        = (state == MULW && !mul_valid && !flush) || (mul_valid && !mul_issued);

    // next state and result capture; flush never abandons a divide already started
    always_comb begin
        state_n = state;
        res_n   = alu_result;
        cap     = 1'b0;
        if (flush && state != DRAIN) begin
            state_n = (state == DIVW || (state == EXEC && is_div)) ? DRAIN : EMPTY;
        end else begin
            case (state)
                EMPTY: state_n = accept ? EXEC : EMPTY;
                EXEC: begin
                    state_n = is_mul ? MULW : (!is_div || alu_complete) ? HOLD : DIVW;
                    cap     = !is_mul && (!is_div || alu_complete);
                end
                MULW: begin
                    state_n = HOLD;
                    cap     = 1'b1;
                    res_n   = mul_result;
                end
                DIVW: begin
                    state_n = alu_complete ? HOLD : DIVW;
                    cap     = alu_complete;
                end
                HOLD:    state_n = !ms_allowin ? HOLD : accept ? EXEC : EMPTY;
                DRAIN:   state_n = alu_complete ? EMPTY : DRAIN;
                default: state_n = EMPTY;
            endcase
        end
    end

    // state, operand/result registers, divide watchdog and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= EMPTY;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            res_q       <= '0;
            cnt         <= '0;
            mul_issued  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q   <= ds_alu_op;
                src1_q <= ds_src1;
                src2_q <= ds_src2;
                dest_q <= ds_dest;
            end
            if (cap) res_q <= res_n;
            cnt         <= div_wait ? cnt + CW'(cnt != CMAX) : '0;
            mul_issued  <= state == EXEC && is_mul;
            err_timeout <= err_timeout || mul_err || (div_wait && cnt == CMAX - CW'(1));
        end
    end
endmodule

// File: tb/tb_ex_muldiv_issue.sv
// tb_ex_muldiv_issue: randomized self-checking bench with a behavioural ALU and reference results
module tb_ex_muldiv_issue;
    localparam int DW = 32, OPW = 19;
    logic           clk = 0, reset = 1;
    logic           ds_to_es_valid = 0, flush = 0, ms_allowin = 1;
    logic [OPW-1:0] ds_alu_op = '0;
    logic [DW-1:0]  ds_src1 = '0, ds_src2 = '0;
    logic [4:0]     ds_dest = '0;
    logic           es_allowin, es_to_ms_valid, es_busy, err_timeout;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_src1, alu_src2, alu_result, mul_result, es_result;
    logic [4:0]     es_dest;
    logic           alu_complete, mul_valid;
    int             dcyc, dlat = 0, checks = 0, failures = 0;
    logic           stuck = 0, no_mul = 0;
    int             kt[12] = '{0, 1, 2, 3, 4, 12, 13, 14, 15, 16, 17, 18};

    ex_muldiv_issue dut (
        .clk(clk), .reset(reset), .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_dest(ds_dest),
        .flush(flush), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .alu_complete(alu_complete), .mul_valid(mul_valid),
        .mul_result(mul_result), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_result(es_result), .es_dest(es_dest), .es_busy(es_busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_fn(input logic [OPW-1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0] pu;
        ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        pu = {32'b0, a} * {32'b0, b};
        if (op[0]) return a + b;
        if (op[1]) return a - b;
        if (op[2]) return a & b;
        if (op[3]) return a | b;
        if (op[4]) return a ^ b;
        if (op[12]) return pu[31:0];
        if (op[13]) return ps[63:32];
        if (op[14]) return pu[63:32];
        if (op[15]) return $signed(a) / $signed(b);
        if (op[16]) return a / b;
        if (op[17]) return $signed(a) % $signed(b);
        if (op[18]) return a % b;
        return 32'h0;
    endfunction

    // behavioural ALU: divide completes after dlat cycles of a held div op; garbage until then
    assign alu_complete = !stuck && (!(|alu_op[18:15]) || dcyc >= dlat);
    assign alu_result   = (|alu_op[18:15] && !alu_complete) ? 32'hDEAD_BEEF :
                          (|alu_op[14:12]) ? 32'hBAD0_0000 : ref_fn(alu_op, alu_src1, alu_src2);

    // behavioural multiplier (result one cycle after issue) and divide cycle counter
    always @(posedge clk) begin
        if (reset) begin
            dcyc       <= 0;
            mul_valid  <= 1'b0;
            mul_result <= '0;
        end else begin
            dcyc       <= (|alu_op[18:15]) ? dcyc + 1 : 0;
            mul_valid  <= (|alu_op[14:12]) && !no_mul;
            mul_result <= ref_fn(alu_op, alu_src1, alu_src2);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // accept one op from an empty stage and follow it to MEM, checking timing and values
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                          input int dl, input logic [31:0] exp);
        logic [OPW-1:0] op;
        int lat;
        logic mul;
        op  = OPW'(1) << k;
        mul = k >= 12 && k <= 14;
        lat = k >= 15 ? 2 + dl : mul ? 3 : 2;
        dlat = dl;
        ds_to_es_valid = 1; ds_alu_op = op; ds_src1 = a; ds_src2 = b; ds_dest = d; ms_allowin = 1;
        #1;
        chk("accept_allowin", es_allowin, 1);
        tick();
        ds_to_es_valid = 0;
        #1;
        for (int i = 1; i <= lat; i++) begin
            chk("alu_op", alu_op, (i < lat && !(mul && i == 2)) ? op : '0);
            chk("valid_timing", es_to_ms_valid, i == lat);
            if (i < lat) begin
                chk("alu_src1", alu_src1, a);
                chk("alu_src2", alu_src2, b);
            end else begin
                chk("es_result", es_result, exp);
                chk("es_dest", es_dest, d);
            end
            tick();
            #1;
        end
        chk("valid_one_cycle", es_to_ms_valid, 0);
        chk("idle_busy", es_busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        #1;
        chk("rst_allowin", es_allowin, 0);
        chk("rst_valid", es_to_ms_valid, 0);
        chk("rst_busy", es_busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_result", es_result, 0);
        chk("rst_dest", es_dest, 0);
        chk("rst_err", err_timeout, 0);
        reset = 0;
        tick();
        run_op(0, 5, 7, 5'd3, 0, 32'd12);
        run_op(12, 32'hFFFF_FFFF, 2, 5'd4, 0, 32'hFFFF_FFFE);
        run_op(14, 32'hFFFF_FFFF, 2, 5'd5, 0, 32'h1);
        run_op(15, 100, 7, 5'd6, 33, 32'd14);
        run_op(17, 100, 7, 5'd7, 33, 32'd2);
        run_op(16, 9, 3, 5'd8, 0, 32'd3);
        chk("no_err_after_div", err_timeout, 0);
        for (int n = 0; n < 40; n++) begin
            int k, dl;
            logic [31:0] a, b;
            k = kt[$urandom_range(0, 11)];
            a = $urandom;
            b = $urandom;
            if (k >= 15) begin
                b = b | 32'h1;
                if (b == 32'hFFFF_FFFF) b = 32'd3;
            end
            dl = $urandom_range(0, 6);
            run_op(k, a, b, 5'($urandom_range(0, 31)), dl, ref_fn(OPW'(1) << k, a, b));
        end
        // flush on the 5th divide-wait cycle drains the divider, then a pending add goes through
        dlat = 20;
        ds_to_es_valid = 1; ds_alu_op = OPW'(1) << 15; ds_src1 = 1000; ds_src2 = 3; ds_dest = 5'd1;
        tick();
        ds_to_es_valid = 0;
        repeat (5) tick();
        flush = 1;
        #1;
        chk("flush_allowin", es_allowin, 0);
        tick();
        flush = 0;
        ds_to_es_valid = 1; ds_alu_op = OPW'(1); ds_src1 = 20; ds_src2 = 22; ds_dest = 5'd9;
        #1;
        for (int c = 7; c <= 21; c++) begin
            chk("drain_allowin", es_allowin, 0);
            chk("drain_valid", es_to_ms_valid, 0);
            chk("drain_op", alu_op, OPW'(1) << 15);
            chk("drain_busy", es_busy, 1);
            tick();
            #1;
        end
        chk("post_drain_allowin", es_allowin, 1);
        tick();
        ds_to_es_valid = 0;
        #1;
        chk("post_drain_exec", es_to_ms_valid, 0);
        tick();
        #1;
        chk("post_drain_valid", es_to_ms_valid, 1);
        chk("post_drain_result", es_result, 42);
        chk("post_drain_dest", es_dest, 9);
        tick();
        // MEM stalls a held result for 4 cycles with the next op waiting
        ds_to_es_valid = 1; ds_alu_op = OPW'(1); ds_src1 = 1; ds_src2 = 2; ds_dest = 5'd1; ms_allowin = 1;
        tick();
        ds_alu_op = OPW'(2); ds_src1 = 10; ds_src2 = 4; ds_dest = 5'd2; ms_allowin = 0;
        #1;
        chk("stall_exec_valid", es_to_ms_valid, 0);
        tick();
        #1;
        for (int c = 2; c <= 5; c++) begin
            chk("stall_valid", es_to_ms_valid, 1);
            chk("stall_result", es_result, 3);
            chk("stall_dest", es_dest, 1);
            chk("stall_allowin", es_allowin, 0);
            tick();
            #1;
        end
        ms_allowin = 1;
        #1;
        chk("handoff_allowin", es_allowin, 1);
        chk("handoff_valid", es_to_ms_valid, 1);
        chk("handoff_result", es_result, 3);
        tick();
        ds_to_es_valid = 0;
        #1;
        chk("second_exec", es_to_ms_valid, 0);
        tick();
        #1;
        chk("second_valid", es_to_ms_valid, 1);
        chk("second_result", es_result, 6);
        chk("second_dest", es_dest, 2);
        tick();
        // reset while waiting on the divider
        dlat = 20;
        ds_to_es_valid = 1; ds_alu_op = OPW'(1) << 16; ds_src1 = 50; ds_src2 = 5; ds_dest = 5'd3;
        tick();
        ds_to_es_valid = 0;
        repeat (3) tick();
        reset = 1;
        tick();
        #1;
        chk("rstdiv_alu_op", alu_op, 0);
        chk("rstdiv_busy", es_busy, 0);
        chk("rstdiv_valid", es_to_ms_valid, 0);
        chk("rstdiv_allowin", es_allowin, 0);
        reset = 0;
        #1;
        chk("rstdiv_allowin_rel", es_allowin, 1);
        tick();
        // divider that never completes trips the sticky watchdog
        stuck = 1;
        dlat = 1;
        ds_to_es_valid = 1; ds_alu_op = OPW'(1) << 15; ds_src1 = 9; ds_src2 = 3; ds_dest = 5'd4;
        tick();
        ds_to_es_valid = 0;
        repeat (34) tick();
        #1;
        chk("timeout_early", err_timeout, 0);
        repeat (10) tick();
        #1;
        chk("timeout_set", err_timeout, 1);
        chk("timeout_busy", es_busy, 1);
        chk("timeout_novalid", es_to_ms_valid, 0);
        stuck = 0;
        tick();
        #1;
        chk("timeout_late_valid", es_to_ms_valid, 1);
        chk("timeout_late_result", es_result, 3);
        repeat (3) tick();
        #1;
        chk("timeout_sticky", err_timeout, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("timeout_cleared", err_timeout, 0);
        tick();
        // multiply whose result strobe never arrives
        no_mul = 1;
        ds_to_es_valid = 1; ds_alu_op = OPW'(1) << 12; ds_src1 = 3; ds_src2 = 5; ds_dest = 5'd2;
        tick();
        ds_to_es_valid = 0;
        tick();
        tick();
        #1;
        chk("nomul_valid", es_to_ms_valid, 1);
        chk("nomul_err", err_timeout, 1);
        no_mul = 0;
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("nomul_cleared", err_timeout, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
